// File: rtl/num_input_collector_if.sv
// Element handshake between the input collector and the matrix/storage logic.
// The collector is the master: it offers out_data with out_valid, and the
// storage side answers with out_ready.
interface num_input_collector_if;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/num_input_collector.sv
// Number input collector: debounces the confirm/clear push-buttons, samples
// the value switches on each confirm press and offers accepted elements to
// the storage logic over a valid/ready handshake. It also keeps the running
// element count and an out-of-range error flag for the FSM and display.
module num_input_collector #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int MAX_VAL         = 9,
  parameter int MAX_COUNT       = 25
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         btn_confirm_i,
  input  logic                         btn_clear_i,
  input  logic [3:0]                   sw_data_i,
  input  logic [2:0]                   sw_mode_i,
  num_input_collector_if.master        out_if,
  output logic [7:0]                   in_count_o,
  output logic                         full_o,
  output logic                         err_flag_o
);

  localparam int             CW        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]     VAL_LIMIT = 5'(MAX_VAL);
  localparam logic [7:0]     COUNT_MAX = 8'(MAX_COUNT);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  // Button index 0 is confirm, index 1 is clear.
  logic [1:0]         btnRaw;
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         level_q, level_d;
  logic [1:0]         levelPrev_q;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         pressPulse;
  logic               confirmPulse, clearPulse;

  logic [0:0]         state_q, state_d;
  logic               valid_q, valid_d;
  logic [3:0]         data_q, data_d;
  logic [7:0]         count_q, count_d;
  logic               full_q, full_d;
  logic               err_q, err_d;
  logic [7:0]         countInc;

  assign btnRaw = {btn_clear_i, btn_confirm_i};

  // Two-flop synchronizers bring the raw buttons into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btnRaw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a level only flips after the input has disagreed with it for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != level_q[b]) begin
        if (cnt_q[b] == CNT_LAST) begin
          level_d[b] = ~level_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // Debounced levels, their counters and the previous level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= '0;
      levelPrev_q <= '0;
      cnt_q       <= '0;
    end else begin
      level_q     <= level_d;
      levelPrev_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  // One pulse per debounced press; release and hold produce nothing more.
  assign pressPulse   = level_q & ~levelPrev_q;
  assign confirmPulse = pressPulse[0];
  assign clearPulse   = pressPulse[1];

  assign countInc = (count_q == COUNT_MAX) ? count_q : count_q + 8'd1;

  // Element FSM: clear wins over everything, IDLE validates a press, OFFER
  // holds the element until the storage side takes it.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    if (clearPulse) begin
      state_d = IDLE;
      valid_d = 1'b0;
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (confirmPulse && (sw_mode_i == 3'b000) && !full_q) begin
            if ({1'b0, sw_data_i} <= VAL_LIMIT) begin
              data_d  = sw_data_i;
              valid_d = 1'b1;
              err_d   = 1'b0;
              state_d = OFFER;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        OFFER: begin
          if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
            count_d = countInc;
            full_d  = (countInc == COUNT_MAX);
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign in_count_o       = count_q;
  assign full_o           = full_q;
  assign err_flag_o       = err_q;

endmodule

// File: tb/tb_num_input_collector.sv
// Testbench for num_input_collector with a short debounce window. A
// press-level reference model predicts count, flags and handshake traffic.
module tb_num_input_collector;

  localparam int D    = 4;
  localparam int MAXV = 9;
  localparam int MAXC = 3;
  localparam int WIN  = 34;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btnConfirm = 1'b0;
  logic       btnClear = 1'b0;
  logic [3:0] swData = '0;
  logic [2:0] swMode = '0;
  logic [7:0] inCount;
  logic       full;
  logic       errFlag;

  num_input_collector_if outIf ();

  num_input_collector #(
    .DEBOUNCE_CYCLES(D),
    .MAX_VAL(MAXV),
    .MAX_COUNT(MAXC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_confirm_i(btnConfirm),
    .btn_clear_i(btnClear),
    .sw_data_i(swData),
    .sw_mode_i(swMode),
    .out_if(outIf),
    .in_count_o(inCount),
    .full_o(full),
    .err_flag_o(errFlag)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: elements entered, flags and the element on offer.
  int mCount   = 0;
  bit mFull    = 0;
  bit mErr     = 0;
  bit mPending = 0;
  int mData    = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests++;
    if (observed != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic bit modelConfirm(input int data, input int mode);
    bit accepted = 0;
    if (!mPending && mode == 0 && !mFull) begin
      if (data <= MAXV) begin
        mPending = 1;
        mData    = data;
        mErr     = 0;
        accepted = 1;
      end else begin
        mErr = 1;
      end
    end
    return accepted;
  endfunction

  function automatic void modelTransfer();
    if (mPending) begin
      mPending = 0;
      if (mCount < MAXC) mCount++;
      mFull = (mCount == MAXC);
    end
  endfunction

  function automatic void modelClear();
    mPending = 0;
    mCount   = 0;
    mFull    = 0;
    mErr     = 0;
  endfunction

  task automatic checkState(input string tag);
    checkOutput({tag, ".valid"}, int'(outIf.out_valid), int'(mPending));
    checkOutput({tag, ".count"}, int'(inCount), mCount);
    checkOutput({tag, ".full"}, int'(full), int'(mFull));
    checkOutput({tag, ".err"}, int'(errFlag), int'(mErr));
    if (mPending) checkOutput({tag, ".data"}, int'(outIf.out_data), mData);
  endtask

  // Drives one button window sample by sample on falling edges, counting
  // handshake transfers and the first new rise of out_valid.
  task automatic applyStimulus(input int confHold, input bit glitch, input int clrHold,
                               output int transfers, output int riseIdx, output int riseData);
    bit prevValid = 1;
    transfers = 0;
    riseIdx   = -1;
    riseData  = 0;
    for (int k = 0; k < WIN; k++) begin
      btnConfirm = glitch ? (k < 4 && (k % 2) == 0) : (k < confHold);
      btnClear   = (k < clrHold);
      if (outIf.out_valid && outIf.out_ready) transfers++;
      if (outIf.out_valid && !prevValid && riseIdx < 0) begin
        riseIdx  = k;
        riseData = int'(outIf.out_data);
      end
      prevValid = outIf.out_valid;
      @(negedge clk);
    end
    btnConfirm = 1'b0;
    btnClear   = 1'b0;
  endtask

  task automatic pressConfirm(input string tag, input int data, input int mode,
                              input bit ready, input int hold);
    int  tr, rise, rdata;
    bit  wasPending = mPending;
    bit  accepted;
    swData          = 4'(data);
    swMode          = 3'(mode);
    outIf.out_ready = ready;
    if (ready) modelTransfer();
    accepted = modelConfirm(data, mode);
    if (ready) modelTransfer();
    applyStimulus(hold, 1'b0, 0, tr, rise, rdata);
    checkOutput({tag, ".transfers"}, tr, ready ? (int'(wasPending) + int'(accepted)) : 0);
    checkOutput({tag, ".rise"}, rise, accepted ? D + 3 : -1);
    if (accepted) checkOutput({tag, ".offered"}, rdata, data);
    checkState(tag);
  endtask

  task automatic pressClear(input string tag, input bit ready, input bit withConfirm);
    int tr, rise, rdata;
    bit wasPending = mPending;
    outIf.out_ready = ready;
    if (ready) modelTransfer();
    modelClear();
    applyStimulus(withConfirm ? 8 : 0, 1'b0, 8, tr, rise, rdata);
    checkOutput({tag, ".transfers"}, tr, int'(ready && wasPending));
    checkOutput({tag, ".rise"}, rise, -1);
    checkState(tag);
  endtask

  task automatic quietWindow(input string tag, input bit ready, input bit glitch);
    int tr, rise, rdata;
    bit wasPending = mPending;
    outIf.out_ready = ready;
    if (ready) modelTransfer();
    applyStimulus(0, glitch, 0, tr, rise, rdata);
    checkOutput({tag, ".transfers"}, tr, int'(ready && wasPending));
    checkOutput({tag, ".rise"}, rise, -1);
    checkState(tag);
  endtask

  initial begin
    outIf.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkState("resetHeld");
    rst_n = 1'b1;
    @(negedge clk);
    checkState("resetReleased");

    // Held press gives one element; bounces give nothing.
    pressConfirm("hold20", 7, 0, 1'b1, 20);
    quietWindow("bounce", 1'b1, 1'b1);

    // Out-of-range value sets the flag, a legal one clears it.
    pressConfirm("tooBig", 12, 0, 1'b1, 8);
    pressConfirm("afterErr", 3, 0, 1'b1, 8);

    // Back-pressure: element held stable, second press dropped.
    pressClear("clr1", 1'b1, 1'b0);
    pressConfirm("stall", 5, 0, 1'b0, 8);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall.heldValid", int'(outIf.out_valid), 1);
      checkOutput("stall.heldData", int'(outIf.out_data), 5);
      @(negedge clk);
    end
    pressConfirm("dropped", 8, 0, 1'b0, 8);
    quietWindow("drain", 1'b1, 1'b0);

    // Saturation at MAX_COUNT.
    pressClear("clr2", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pressConfirm("fill", i + 1, 0, 1'b1, 8);
    pressClear("clrFull", 1'b1, 1'b0);

    // Wrong mode, then clear and confirm together while offering.
    pressConfirm("mode3", 4, 3, 1'b1, 8);
    pressConfirm("offerBoth", 2, 0, 1'b0, 8);
    pressClear("both", 1'b0, 1'b1);

    // Asynchronous reset while an element is pending and a press is debouncing.
    pressConfirm("preReset", 6, 0, 1'b1, 8);
    pressConfirm("pendReset", 1, 0, 1'b0, 8);
    btnConfirm = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    modelClear();
    checkState("asyncReset");
    btnConfirm = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkState("postReset");

    // Randomized mix of presses, clears, bounces and idle windows.
    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 9);
      if (r == 0) begin
        pressClear("rndClear", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r == 1) begin
        quietWindow("rndBounce", 1'($urandom_range(0, 1)), 1'b1);
      end else if (r == 2) begin
        quietWindow("rndIdle", 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        pressConfirm("rndPress", $urandom_range(0, 15),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0,
                     1'($urandom_range(0, 1)), $urandom_range(D + 2, 20));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
